batch_tid_dispatcher: RTL and testbench

Successor to the single-lane thread-ID dispatcher in the CGRA subsystem. It issues thread IDs in batches of LANES per cycle over a valid/ready handshake, and supports backpressure. It generates 3D (x,y,z) coordinates with incremental carry counters instead of divide/modulo. It sits between the kernel launch control and the CGRA lane dispatch logic.

---
 rtl/batch_tid_dispatcher.sv | 215 +++++++++++++++++++++
 tb/tb_batch_tid_dispatcher.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/batch_tid_dispatcher.sv
// batch_tid_dispatcher
//
// Issues thread IDs LANES at a time over a valid/ready handshake. Each lane
// also carries the thread's (x,y,z) coordinates inside the launch grid. The
// coordinates come from a chain of carry incrementers, so no divide or
// modulo hardware is needed.
//
// Ports:
//   clk           clock; all logic on posedge
//   rst           synchronous active-high reset
//   start         launch pulse, honoured only in IDLE
//   clr           synchronous abort/clear from any state (beats start/handshake)
//   max_tid       last thread ID (inclusive), latched at start
//   ntid_x/y/z    grid dimensions minus one, latched at start
//   out_valid     batch valid (high in RUN)
//   out_ready     consumer accepts the presented batch
//   out_lane_mask bit i set when lane i carries a real thread
//   out_tid       lane i flat tid at [i*TIDW +: TIDW]
//   out_tid_x/y/z lane i coordinates, same packing as out_tid
//   busy          state is RUN
//   done          state is DONE
module batch_tid_dispatcher #(
  parameter int TOTAL_TID = 512,
  parameter int LANES     = 4,
  localparam int TIDW     = $clog2(TOTAL_TID)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   clr,
  input  logic [TIDW-1:0]        max_tid,
  input  logic [TIDW-1:0]        ntid_x,
  input  logic [TIDW-1:0]        ntid_y,
  input  logic [TIDW-1:0]        ntid_z,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES-1:0]       out_lane_mask,
  output logic [LANES*TIDW-1:0]  out_tid,
  output logic [LANES*TIDW-1:0]  out_tid_x,
  output logic [LANES*TIDW-1:0]  out_tid_y,
  output logic [LANES*TIDW-1:0]  out_tid_z,
  output logic                   busy,
  output logic                   done
);

  // Wide enough for base + LANES without overflow, even when max_tid is
  // all ones and LANES is large.
  localparam int SW = TIDW + $clog2(LANES + 1) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  logic [TIDW:0]     base;
  logic [TIDW-1:0]   base_x;
  logic [TIDW-1:0]   base_y;
  logic [TIDW-1:0]   base_z;
  logic [TIDW-1:0]   cfg_max;
  logic [TIDW-1:0]   cfg_nx;
  logic [TIDW-1:0]   cfg_ny;
  logic [TIDW-1:0]   cfg_nz;

  logic [TIDW-1:0]   lane_x [LANES];
  logic [TIDW-1:0]   lane_y [LANES];
  logic [TIDW-1:0]   lane_z [LANES];
  logic [TIDW-1:0]   next_base_x;
  logic [TIDW-1:0]   next_base_y;
  logic [TIDW-1:0]   next_base_z;

  logic              handshake;
  logic              last_batch;

  // One step of the grid walk: x counts up to nx, then wraps and carries
  // into y, which wraps into z, which wraps to zero. Returns {z, y, x}.
  function automatic logic [3*TIDW-1:0] coord_inc(
    input logic [TIDW-1:0] x,
    input logic [TIDW-1:0] y,
    input logic [TIDW-1:0] z,
    input logic [TIDW-1:0] nx,
    input logic [TIDW-1:0] ny,
    input logic [TIDW-1:0] nz
  );
    logic [TIDW-1:0] rx;
    logic [TIDW-1:0] ry;
    logic [TIDW-1:0] rz;
    rx = x;
    ry = y;
    rz = z;
    if (x == nx) begin
      rx = '0;
      if (y == ny) begin
        ry = '0;
        rz = (z == nz) ? '0 : z + 1'b1;
      end else begin
        ry = y + 1'b1;
      end
    end else begin
      rx = x + 1'b1;
    end
    return {rz, ry, rx};
  endfunction

  assign handshake  = out_valid & out_ready;
  assign last_batch = (SW'(base) + SW'(LANES)) > SW'(cfg_max);

  // Coordinate chain: lane 0 starts at the base coordinates and each later
  // lane is one increment past its neighbour. One more increment past the
  // last lane gives the base coordinates of the following batch.
  always_comb begin
    logic [TIDW-1:0] cx;
    logic [TIDW-1:0] cy;
    logic [TIDW-1:0] cz;
    cx = base_x;
    cy = base_y;
    cz = base_z;
    for (int i = 0; i < LANES; i++) begin
      lane_x[i] = cx;
      lane_y[i] = cy;
      lane_z[i] = cz;
      {cz, cy, cx} = coord_inc(cx, cy, cz, cfg_nx, cfg_ny, cfg_nz);
    end
    next_base_x = cx;
    next_base_y = cy;
    next_base_z = cz;
  end

  // Lane outputs depend only on registered state, so they hold steady
  // while the consumer stalls. Lanes past max_tid, and every lane outside
  // RUN, read as zero.
  always_comb begin
    logic [SW-1:0] lane_sum;
    out_lane_mask = '0;
    out_tid       = '0;
    out_tid_x     = '0;
    out_tid_y     = '0;
    out_tid_z     = '0;
    lane_sum      = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_sum = SW'(base) + SW'(i);
      if ((state == RUN) && (lane_sum <= SW'(cfg_max))) begin
        out_lane_mask[i]            = 1'b1;
        out_tid[i*TIDW +: TIDW]     = lane_sum[TIDW-1:0];
        out_tid_x[i*TIDW +: TIDW]   = lane_x[i];
        out_tid_y[i*TIDW +: TIDW]   = lane_y[i];
        out_tid_z[i*TIDW +: TIDW]   = lane_z[i];
      end
    end
  end

  // Control FSM with registered status outputs. clr overrides every other
  // event, including a start or a handshake in the same cycle. On the final
  // handshake, base is left where it is because nothing reads it in DONE.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state     <= IDLE;
      base      <= '0;
      base_x    <= '0;
      base_y    <= '0;
      base_z    <= '0;
      cfg_max   <= '0;
      cfg_nx    <= '0;
      cfg_ny    <= '0;
      cfg_nz    <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cfg_max   <= max_tid;
            cfg_nx    <= ntid_x;
            cfg_ny    <= ntid_y;
            cfg_nz    <= ntid_z;
            base      <= '0;
            base_x    <= '0;
            base_y    <= '0;
            base_z    <= '0;
            state     <= RUN;
            out_valid <= 1'b1;
            busy      <= 1'b1;
          end
        end
        RUN: begin
          if (handshake) begin
            if (last_batch) begin
              state     <= DONE;
              out_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
            end else begin
              base   <= base + (TIDW + 1)'(LANES);
              base_x <= next_base_x;
              base_y <= next_base_y;
              base_z <= next_base_z;
            end
          end
        end
        DONE: begin
          done <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_batch_tid_dispatcher.sv
// tb_batch_tid_dispatcher
//
// Testbench for batch_tid_dispatcher. It drives launches from a table of
// configurations plus randomized ones. The reference model computes every
// lane's tid and coordinates with plain divide/modulo arithmetic. A few
// hand-written sequences cover stalls, clr, start in DONE and a mid-run reset.
module tb_batch_tid_dispatcher;

  localparam int TOTAL_TID = 512;
  localparam int LANES     = 4;
  localparam int TIDW      = $clog2(TOTAL_TID);
  localparam int BUDGET    = 3000;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  start;
  logic                  clr;
  logic [TIDW-1:0]       max_tid;
  logic [TIDW-1:0]       ntid_x;
  logic [TIDW-1:0]       ntid_y;
  logic [TIDW-1:0]       ntid_z;
  logic                  out_valid;
  logic                  out_ready;
  logic [LANES-1:0]      out_lane_mask;
  logic [LANES*TIDW-1:0] out_tid;
  logic [LANES*TIDW-1:0] out_tid_x;
  logic [LANES*TIDW-1:0] out_tid_y;
  logic [LANES*TIDW-1:0] out_tid_z;
  logic                  busy;
  logic                  done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int               mx;
    int               nx;
    int               ny;
    int               nz;
    int               exp_batches;
    logic [LANES-1:0] last_mask;
    int               probe;
    int               px;
    int               py;
    int               pz;
    int               ready_pct;
  } vec_t;

  vec_t vecs [8];

  batch_tid_dispatcher #(.TOTAL_TID(TOTAL_TID), .LANES(LANES)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .clr           (clr),
    .max_tid       (max_tid),
    .ntid_x        (ntid_x),
    .ntid_y        (ntid_y),
    .ntid_z        (ntid_z),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_lane_mask (out_lane_mask),
    .out_tid       (out_tid),
    .out_tid_x     (out_tid_x),
    .out_tid_y     (out_tid_y),
    .out_tid_z     (out_tid_z),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  // Compare one observed value against its expected value and log any miss.
  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive all control and config inputs at once.
  task automatic applyStimulus(input logic st, input logic cl, input logic rdy,
                               input int mx, input int nx, input int ny, input int nz);
    start     = st;
    clr       = cl;
    out_ready = rdy;
    max_tid   = TIDW'(mx);
    ntid_x    = TIDW'(nx);
    ntid_y    = TIDW'(ny);
    ntid_z    = TIDW'(nz);
  endtask

  // Reference model: batch b covers tids b*LANES .. b*LANES+LANES-1. The
  // coordinates follow directly from the grid dimensions by divide/modulo.
  function automatic void modelBatch(input int b, input int mx, input int nx, input int ny, input int nz,
                                     output logic [LANES-1:0] m, output logic [LANES*TIDW-1:0] t,
                                     output logic [LANES*TIDW-1:0] x, output logic [LANES*TIDW-1:0] y,
                                     output logic [LANES*TIDW-1:0] z);
    int tid;
    m = '0; t = '0; x = '0; y = '0; z = '0;
    for (int i = 0; i < LANES; i++) begin
      tid = b * LANES + i;
      if (tid <= mx) begin
        m[i]                = 1'b1;
        t[i*TIDW +: TIDW]   = TIDW'(tid);
        x[i*TIDW +: TIDW]   = TIDW'(tid % (nx + 1));
        y[i*TIDW +: TIDW]   = TIDW'((tid / (nx + 1)) % (ny + 1));
        z[i*TIDW +: TIDW]   = TIDW'((tid / ((nx + 1) * (ny + 1))) % (nz + 1));
      end
    end
  endfunction

  // Return the DUT to IDLE with a one-cycle clr pulse.
  task automatic clrPulse();
    applyStimulus(1'b0, 1'b1, 1'b0, 0, 0, 0, 0);
    @(negedge clk);
    clr = 1'b0;
    checkOutput("clr_done_low", done, 1'b0);
    checkOutput("clr_valid_low", out_valid, 1'b0);
  endtask

  // Run one full launch and check every presented batch against the model.
  // Ready is randomized per cycle. Each cycle without a handshake must leave
  // the outputs unchanged.
  task automatic runLaunch(input vec_t v, input string tag, output int nb,
                           output int gx, output int gy, output int gz,
                           output logic [LANES-1:0] lm);
    logic [LANES-1:0]      em;
    logic [LANES*TIDW-1:0] et, ex, ey, ez;
    logic [LANES*TIDW-1:0] s_tid, s_x;
    logic [LANES-1:0]      s_mask;
    logic                  have_snap;
    logic                  prev_hs;
    logic                  rdy;
    int                    cyc;
    int                    k;
    nb = 0; gx = -1; gy = -1; gz = -1; lm = '0;
    have_snap = 1'b0; prev_hs = 1'b0; cyc = 0;
    s_tid = '0; s_x = '0; s_mask = '0;
    applyStimulus(1'b1, 1'b0, 1'b0, v.mx, v.nx, v.ny, v.nz);
    @(negedge clk);
    start = 1'b0;
    checkOutput({tag, "_valid_rise"}, out_valid, 1'b1);
    while (out_valid === 1'b1 && cyc < BUDGET) begin
      modelBatch(nb, v.mx, v.nx, v.ny, v.nz, em, et, ex, ey, ez);
      checkOutput($sformatf("%s_b%0d_mask", tag, nb), out_lane_mask, em);
      checkOutput($sformatf("%s_b%0d_tid", tag, nb), out_tid, et);
      checkOutput($sformatf("%s_b%0d_x", tag, nb), out_tid_x, ex);
      checkOutput($sformatf("%s_b%0d_y", tag, nb), out_tid_y, ey);
      checkOutput($sformatf("%s_b%0d_z", tag, nb), out_tid_z, ez);
      checkOutput($sformatf("%s_b%0d_busy", tag, nb), busy, 1'b1);
      if (have_snap) begin
        checkOutput($sformatf("%s_b%0d_hold_tid", tag, nb), out_tid, s_tid);
        checkOutput($sformatf("%s_b%0d_hold_x", tag, nb), out_tid_x, s_x);
        checkOutput($sformatf("%s_b%0d_hold_mask", tag, nb), out_lane_mask, s_mask);
      end
      rdy = ($urandom_range(99) < v.ready_pct);
      out_ready = rdy;
      if (rdy) begin
        k = v.probe - nb * LANES;
        if (v.probe >= 0 && k >= 0 && k < LANES) begin
          gx = int'(out_tid_x[k*TIDW +: TIDW]);
          gy = int'(out_tid_y[k*TIDW +: TIDW]);
          gz = int'(out_tid_z[k*TIDW +: TIDW]);
        end
        lm = out_lane_mask;
        nb++;
        have_snap = 1'b0;
      end else begin
        s_tid = out_tid; s_x = out_tid_x; s_mask = out_lane_mask;
        have_snap = 1'b1;
      end
      prev_hs = rdy;
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b0;
    if (cyc >= BUDGET) checkOutput({tag, "_timeout"}, 1'b0, 1'b1);
    checkOutput({tag, "_done"}, done, 1'b1);
    checkOutput({tag, "_done_after_hs"}, prev_hs, 1'b1);
    checkOutput({tag, "_busy_off"}, busy, 1'b0);
    checkOutput({tag, "_mask_off"}, out_lane_mask, '0);
  endtask

  initial begin
    int               nb, gx, gy, gz;
    logic [LANES-1:0] lm;
    logic [LANES*TIDW-1:0] s_tid, s_x, s_y;
    logic [LANES-1:0] s_mask;
    vec_t             rv;

    vecs[0] = '{9,   3,   2, 0, 3,   4'b0011, 9,   1,   2, 0, 100};
    vecs[1] = '{9,   3,   2, 0, 3,   4'b0011, 6,   2,   1, 0, 50};
    vecs[2] = '{0,   5,   5, 5, 1,   4'b0001, 0,   0,   0, 0, 100};
    vecs[3] = '{7,   1,   1, 1, 2,   4'b1111, 5,   1,   0, 1, 70};
    vecs[4] = '{7,   1,   1, 1, 2,   4'b1111, 7,   1,   1, 1, 100};
    vecs[5] = '{511, 7,   7, 7, 128, 4'b1111, 511, 7,   7, 7, 100};
    vecs[6] = '{10,  2,   1, 0, 3,   4'b0111, 10,  1,   1, 0, 60};
    vecs[7] = '{511, 510, 0, 0, 128, 4'b1111, 510, 510, 0, 0, 100};

    // Reset state
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checkOutput("rst_valid", out_valid, 1'b0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_done", done, 1'b0);
    checkOutput("rst_mask", out_lane_mask, '0);
    checkOutput("rst_tid", out_tid, '0);
    checkOutput("rst_x", out_tid_x, '0);

    // Table-driven launches
    for (int i = 0; i < 8; i++) begin
      runLaunch(vecs[i], $sformatf("vec%0d", i), nb, gx, gy, gz, lm);
      checkOutput($sformatf("vec%0d_batches", i), nb, vecs[i].exp_batches);
      checkOutput($sformatf("vec%0d_last_mask", i), lm, vecs[i].last_mask);
      checkOutput($sformatf("vec%0d_probe_x", i), gx, vecs[i].px);
      checkOutput($sformatf("vec%0d_probe_y", i), gy, vecs[i].py);
      checkOutput($sformatf("vec%0d_probe_z", i), gz, vecs[i].pz);
      clrPulse();
    end

    // Stall on batch 1 for three cycles, then accept
    applyStimulus(1'b1, 1'b0, 1'b1, 9, 3, 2, 0);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    checkOutput("stall_b1_tid", out_tid, {9'd7, 9'd6, 9'd5, 9'd4});
    out_ready = 1'b0;
    s_tid = out_tid; s_x = out_tid_x; s_y = out_tid_y; s_mask = out_lane_mask;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput($sformatf("stall%0d_valid", c), out_valid, 1'b1);
      checkOutput($sformatf("stall%0d_tid", c), out_tid, s_tid);
      checkOutput($sformatf("stall%0d_x", c), out_tid_x, s_x);
      checkOutput($sformatf("stall%0d_y", c), out_tid_y, s_y);
      checkOutput($sformatf("stall%0d_mask", c), out_lane_mask, s_mask);
    end
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("stall_b2_tid", out_tid, {9'd0, 9'd0, 9'd9, 9'd8});
    checkOutput("stall_b2_mask", out_lane_mask, 4'b0011);
    checkOutput("stall_b2_x", out_tid_x, {9'd0, 9'd0, 9'd1, 9'd0});
    checkOutput("stall_b2_y", out_tid_y, {9'd0, 9'd0, 9'd2, 9'd2});
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput("stall_done", done, 1'b1);

    // start is ignored in DONE
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("done_start_ignored_done", done, 1'b1);
    checkOutput("done_start_ignored_valid", out_valid, 1'b0);
    clrPulse();
    checkOutput("done_clr_busy", busy, 1'b0);

    // clr in RUN beats a simultaneous handshake; restart begins at tid 0
    applyStimulus(1'b1, 1'b0, 1'b1, 9, 3, 2, 0);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    checkOutput("clr_run_b1_lane0", out_tid[TIDW-1:0], 9'd4);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    out_ready = 1'b0;
    checkOutput("clr_run_valid", out_valid, 1'b0);
    checkOutput("clr_run_busy", busy, 1'b0);
    checkOutput("clr_run_mask", out_lane_mask, '0);
    @(negedge clk);
    checkOutput("clr_run_idle_valid", out_valid, 1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("restart_valid", out_valid, 1'b1);
    checkOutput("restart_tid", out_tid, {9'd3, 9'd2, 9'd1, 9'd0});
    checkOutput("restart_mask", out_lane_mask, 4'b1111);
    clrPulse();

    // clr and start together in IDLE: stays IDLE
    applyStimulus(1'b1, 1'b1, 1'b0, 9, 3, 2, 0);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 9, 3, 2, 0);
    checkOutput("clr_start_valid", out_valid, 1'b0);
    checkOutput("clr_start_busy", busy, 1'b0);
    @(negedge clk);
    checkOutput("clr_start_valid2", out_valid, 1'b0);

    // Reset in the middle of a run
    applyStimulus(1'b1, 1'b0, 1'b1, 100, 4, 3, 2);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b0;
    checkOutput("midrst_valid", out_valid, 1'b0);
    checkOutput("midrst_busy", busy, 1'b0);
    checkOutput("midrst_done", done, 1'b0);
    checkOutput("midrst_mask", out_lane_mask, '0);
    checkOutput("midrst_tid", out_tid, '0);
    checkOutput("midrst_z", out_tid_z, '0);

    // Randomized launches against the divide/modulo model
    for (int r = 0; r < 25; r++) begin
      rv.mx = $urandom_range(150);
      rv.nx = (r % 5 == 0) ? $urandom_range(40) : $urandom_range(7);
      rv.ny = $urandom_range(7);
      rv.nz = $urandom_range(5);
      rv.exp_batches = (rv.mx + LANES) / LANES;
      rv.last_mask = '0;
      rv.probe = -1; rv.px = -1; rv.py = -1; rv.pz = -1;
      rv.ready_pct = 50 + $urandom_range(50);
      runLaunch(rv, $sformatf("rnd%0d", r), nb, gx, gy, gz, lm);
      checkOutput($sformatf("rnd%0d_batches", r), nb, rv.exp_batches);
      clrPulse();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
